// File: rtl/apu_pkg.sv
// Shared definitions for the APU instruction dispatcher: instruction field
// widths, opcode values and the dispatcher state encoding.
package apu_pkg;

    localparam int INSTR_W = 32;
    localparam int OPC_W   = 4;
    localparam int CFG_W   = INSTR_W - OPC_W;

    localparam int OPC_NOP  = 0;
    localparam int OPC_CONV = 1;
    localparam int OPC_POOL = 2;
    localparam int OPC_ADD  = 3;
    localparam int OPC_FC   = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_ISSUE,
        ST_WAIT,
        ST_DONE
    } apu_state_e;

endpackage

// File: rtl/apu_opc_decode.sv
// Combinational opcode decoder: flags NOP and legal opcodes and produces the
// one-hot engine select (opcode N selects engine N-1).
module apu_opc_decode
    import apu_pkg::*;
#(
    parameter int P_ENGINE_NUM = 4,
    parameter int P_OPC_W      = OPC_W
) (
    input  logic [P_OPC_W-1:0]      opc,
    output logic                    is_nop,
    output logic                    legal,
    output logic [P_ENGINE_NUM-1:0] eng_sel
);

    localparam logic [P_OPC_W-1:0] OPC_LAST = P_OPC_W'(P_ENGINE_NUM);

    always_comb begin
        // NOTE: every output gets a value before any conditional logic, so no latch can be inferred.
        eng_sel = '0;
        is_nop  = (opc == P_OPC_W'(OPC_NOP));
        legal   = (opc <= OPC_LAST);
        for (int i = 0; i < P_ENGINE_NUM; i++) begin
            eng_sel[i] = (opc == P_OPC_W'(i + 1));
        end
    end

endmodule

// File: rtl/apu_instr_dispatcher.sv
// Dispatches worksheet instructions to the APU compute engines and reports
// retirement and sticky status. Optional watchdog: APU_DISPATCH_WATCHDOG_EN.
module apu_instr_dispatcher
    import apu_pkg::*;
#(
    parameter int P_ENGINE_NUM = 4,
    parameter int P_OPC_W      = OPC_W,
    parameter int P_CNT_W      = 16
`ifdef APU_DISPATCH_WATCHDOG_EN
    ,
    parameter int P_WDT_CYCLES = 65535
`endif
) (
    input  logic                        clk,
    input  logic                        nRst,
    input  logic                        iEnable,
    input  logic                        iCtrlnCe,
    input  logic [INSTR_W-1:0]          iInstruction,
    output logic                        oAPUReady,
    output logic                        oComputeDone,
    output logic [P_ENGINE_NUM-1:0]     oEngStart,
    output logic [INSTR_W-P_OPC_W-1:0]  oEngCfg,
    input  logic [P_ENGINE_NUM-1:0]     iEngDone,
    output logic                        oBusy,
    output logic [P_OPC_W-1:0]          oCurOpcode,
    output logic                        oIllegal,
    output logic                        oStrayDone,
    output logic [P_CNT_W-1:0]          oInstrCount,
    input  logic                        iClrStatus
`ifdef APU_DISPATCH_WATCHDOG_EN
    ,
    output logic                        oTimeout
`endif
);

    apu_state_e                state_q, state_d;
    logic [INSTR_W-1:0]        instr_q;
    logic                      is_nop, legal;
    logic [P_ENGINE_NUM-1:0]   eng_sel, start_d;
    logic                      accept, eng_done, stray, illegal_set, wdt_expire;

    assign oCurOpcode = instr_q[INSTR_W-1 -: P_OPC_W];
    assign oEngCfg    = instr_q[INSTR_W-P_OPC_W-1:0];
    assign oBusy      = (state_q != ST_IDLE);

    apu_opc_decode #(
        .P_ENGINE_NUM (P_ENGINE_NUM),
        .P_OPC_W      (P_OPC_W)
    ) u_decode (
        .opc     (oCurOpcode),
        .is_nop  (is_nop),
        .legal   (legal),
        .eng_sel (eng_sel)
    );

    // The cycle carrying oComputeDone is skipped: the worksheet still shows the retired word then.
    assign accept   = (state_q == ST_IDLE) && !oComputeDone && !iCtrlnCe;
    assign eng_done = |(iEngDone & eng_sel);
    assign stray    = (state_q == ST_WAIT) && |(iEngDone & ~eng_sel);

`ifdef APU_DISPATCH_WATCHDOG_EN
    localparam int WDT_W = $clog2(P_WDT_CYCLES + 1);
    logic [WDT_W-1:0] wdt_q;

    assign wdt_expire = (state_q == ST_WAIT) && !eng_done &&
                        (wdt_q == WDT_W'(P_WDT_CYCLES - 1));

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            wdt_q    <= '0;
            oTimeout <= 1'b0;
        end else begin
            wdt_q <= (state_q == ST_WAIT) ? wdt_q + 1'b1 : '0;
            if (iClrStatus)      oTimeout <= 1'b0;
            else if (wdt_expire) oTimeout <= 1'b1;
        end
    end
`else
    assign wdt_expire = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        start_d     = '0;
        illegal_set = 1'b0;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: begin
                if (!legal) begin
                    illegal_set = 1'b1;
                    state_d     = ST_DONE;
                end else if (is_nop) begin
                    state_d = ST_DONE;
                end else begin
                    start_d = eng_sel;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE:  state_d = eng_done ? ST_DONE : ST_WAIT;
            ST_WAIT:   if (eng_done || wdt_expire) state_d = ST_DONE;
            ST_DONE:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nRst) begin
        // NOTE: state uses non-blocking assignments so every flop updates from pre-edge values.
        if (!nRst) begin
            state_q      <= ST_IDLE;
            oAPUReady    <= 1'b0;
            oComputeDone <= 1'b0;
            oEngStart    <= '0;
            oIllegal     <= 1'b0;
            oStrayDone   <= 1'b0;
            oInstrCount  <= '0;
        end else begin
            state_q      <= state_d;
            oAPUReady    <= (state_q == ST_IDLE) && iEnable && iCtrlnCe;
            oComputeDone <= (state_q == ST_DONE);
            oEngStart    <= start_d;
            if (iClrStatus)       oIllegal <= 1'b0;
            else if (illegal_set) oIllegal <= 1'b1;
            if (iClrStatus)       oStrayDone <= 1'b0;
            else if (stray)       oStrayDone <= 1'b1;
            if (iClrStatus)                  oInstrCount <= '0;
            else if (state_q == ST_DONE)     oInstrCount <= oInstrCount + 1'b1;
        end
    end

    // NOTE: the holding register is reset because it drives oEngCfg/oCurOpcode, which must read 0 after reset.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst)       instr_q <= '0;
        else if (accept) instr_q <= iInstruction;
    end

endmodule

// File: tb/tb_apu_instr_dispatcher.sv
// Self-checking bench for apu_instr_dispatcher: directed vector table plus
// hand-written multi-cycle sequences (watchdog case under APU_DISPATCH_WATCHDOG_EN).
module tb_apu_instr_dispatcher;
    import apu_pkg::*;

    logic        clk, nRst, iEnable, iCtrlnCe, iClrStatus;
    logic [31:0] iInstruction;
    logic        oAPUReady, oComputeDone, oBusy, oIllegal, oStrayDone;
    logic [3:0]  oEngStart, iEngDone, oCurOpcode;
    logic [27:0] oEngCfg;
    logic [15:0] oInstrCount;
`ifdef APU_DISPATCH_WATCHDOG_EN
    logic        oTimeout;
`endif

    int checks   = 0;
    int failures = 0;

    apu_instr_dispatcher #(
        .P_ENGINE_NUM (4)
`ifdef APU_DISPATCH_WATCHDOG_EN
        ,
        .P_WDT_CYCLES (8)
`endif
    ) dut (
        .clk          (clk),
        .nRst         (nRst),
        .iEnable      (iEnable),
        .iCtrlnCe     (iCtrlnCe),
        .iInstruction (iInstruction),
        .oAPUReady    (oAPUReady),
        .oComputeDone (oComputeDone),
        .oEngStart    (oEngStart),
        .oEngCfg      (oEngCfg),
        .iEngDone     (iEngDone),
        .oBusy        (oBusy),
        .oCurOpcode   (oCurOpcode),
        .oIllegal     (oIllegal),
        .oStrayDone   (oStrayDone),
        .oInstrCount  (oInstrCount),
        .iClrStatus   (iClrStatus)
`ifdef APU_DISPATCH_WATCHDOG_EN
        ,
        .oTimeout     (oTimeout)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One instruction through a worksheet/engine model; the worksheet drops
    // iCtrlnCe on the edge after it sees oComputeDone, like a registered source.
    task automatic dispatch(input logic [31:0] instr, input int lat,
                            output logic [3:0] start_or, output int start_n,
                            output int done_c, output int pulses,
                            output logic [27:0] cfg_at_done);
        int  start_c;
        bit  drop;
        start_or = '0; start_n = 0; done_c = -1; pulses = 0;
        cfg_at_done = '0; start_c = -1; drop = 0;
        iInstruction = instr;
        iCtrlnCe     = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (c == 1) iInstruction = ~instr;
            if (drop) iCtrlnCe = 1'b1;
            iEngDone = '0;
            if (oEngStart != '0) begin
                start_or |= oEngStart;
                start_n++;
                start_c = c;
            end
            if (oComputeDone) begin
                pulses++;
                if (done_c < 0) done_c = c;
                drop = 1;
            end
            if (start_c >= 0 && c == start_c + lat) begin
                iEngDone    = start_or;
                cfg_at_done = oEngCfg;
            end
            if (done_c >= 0 && c >= done_c + 4) break;
        end
        iCtrlnCe = 1'b1;
        iEngDone = '0;
    endtask

    typedef struct {
        logic [31:0] instr;
        int          lat;
        logic [3:0]  exp_start;
        logic [27:0] exp_cfg;
        int          exp_done_c;
        logic [15:0] exp_count;
        logic        exp_illegal;
    } vec_t;

    vec_t vecs[7];

    initial begin
        logic [3:0]  s_or;
        int          s_n, d_c, pul, idx, extra, start_c;
        logic [27:0] cfg;
        logic [31:0] list[3];
        bit          pend;

        vecs[0] = '{32'h1000_00AB, 10, 4'b0001, 28'h00000AB, 14, 16'd1, 1'b0};
        vecs[1] = '{32'h0000_0000,  0, 4'b0000, 28'h0000000,  3, 16'd2, 1'b0};
        vecs[2] = '{32'h2123_4567,  0, 4'b0010, 28'h1234567,  4, 16'd3, 1'b0};
        vecs[3] = '{32'h3FFF_FFFF,  1, 4'b0100, 28'hFFFFFFF,  5, 16'd4, 1'b0};
        vecs[4] = '{32'h4000_0001,  3, 4'b1000, 28'h0000001,  7, 16'd5, 1'b0};
        vecs[5] = '{32'hF000_0000,  0, 4'b0000, 28'h0000000,  3, 16'd6, 1'b1};
        vecs[6] = '{32'h5000_0000,  0, 4'b0000, 28'h0000000,  3, 16'd7, 1'b1};

        nRst = 1'b0; iEnable = 1'b1; iCtrlnCe = 1'b1; iClrStatus = 1'b0;
        iInstruction = '0; iEngDone = '0;
        tick(); tick();
        check("rst_ready",  oAPUReady,    0);
        check("rst_done",   oComputeDone, 0);
        check("rst_start",  oEngStart,    0);
        check("rst_cfg",    oEngCfg,      0);
        check("rst_busy",   oBusy,        0);
        check("rst_opc",    oCurOpcode,   0);
        check("rst_flags",  {oIllegal, oStrayDone}, 0);
        check("rst_count",  oInstrCount,  0);
        nRst = 1'b1;
        tick();
        check("ready_after_rst", oAPUReady, 1);
        check("idle_busy",       oBusy,     0);

        foreach (vecs[i]) begin
            dispatch(vecs[i].instr, vecs[i].lat, s_or, s_n, d_c, pul, cfg);
            check($sformatf("v%0d_start", i),   s_or, vecs[i].exp_start);
            check($sformatf("v%0d_nstart", i),  s_n,  (vecs[i].exp_start != 0) ? 1 : 0);
            check($sformatf("v%0d_done_at", i), d_c,  vecs[i].exp_done_c);
            check($sformatf("v%0d_pulses", i),  pul,  1);
            check($sformatf("v%0d_count", i),   oInstrCount, vecs[i].exp_count);
            check($sformatf("v%0d_illegal", i), oIllegal,    vecs[i].exp_illegal);
            check($sformatf("v%0d_busy", i),    oBusy,       0);
            if (vecs[i].exp_start != 0)
                check($sformatf("v%0d_cfg", i), cfg, vecs[i].exp_cfg);
        end
        check("no_stray_yet", oStrayDone, 0);

        // Back-to-back list NOP, POOL, FC with a registered worksheet model.
        list[0] = 32'h0000_0000; list[1] = 32'h2000_0011; list[2] = 32'h4000_0022;
        idx = 0; pend = 0; s_n = 0; s_or = '0; pul = 0; start_c = -1; extra = 0;
        iInstruction = list[0]; iCtrlnCe = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            tick();
            iEngDone = '0;
            if (pend) begin
                pend = 0;
                idx++;
                if (idx < 3) iInstruction = list[idx];
                else         iCtrlnCe = 1'b1;
            end
            if (oEngStart != '0) begin
                s_n++;
                s_or |= oEngStart;
                start_c = c;
            end
            if (start_c >= 0 && c == start_c + 2) iEngDone = s_or & ~(s_or - 4'd1) & 4'b0010 | (c > 0 && s_or[3] ? 4'b1000 : 4'b0000);
            if (oComputeDone) begin
                pul++;
                pend = 1;
            end
            if (idx >= 3) begin
                extra++;
                if (extra == 4) break;
            end
        end
        iEngDone = '0;
        check("list_pulses", pul,  3);
        check("list_starts", s_n,  2);
        check("list_engs",   s_or, 4'b1010);
        check("list_count",  oInstrCount, 10);

        // Stray done while POOL is waiting.
        iInstruction = 32'h2000_0055; iCtrlnCe = 1'b0;
        tick();
        tick();
        check("stray_start", oEngStart, 4'b0010);
        tick();
        iEngDone = 4'b1000;
        tick();
        iEngDone = '0;
        check("stray_flag",  oStrayDone,   1);
        check("stray_busy",  oBusy,        1);
        check("stray_nodone", oComputeDone, 0);
        tick();
        check("stray_wait",  oBusy, 1);
        iEngDone = 4'b0010;
        tick();
        iEngDone = '0;
        tick();
        check("stray_retire", oComputeDone, 1);
        check("stray_count",  oInstrCount,  11);
        iCtrlnCe = 1'b1;
        tick();

        iClrStatus = 1'b1;
        tick();
        iClrStatus = 1'b0;
        check("clr_flags", {oIllegal, oStrayDone}, 0);
        check("clr_count", oInstrCount, 0);

        // Clear coinciding with a retirement: the clear wins.
        iInstruction = 32'h0000_0000; iCtrlnCe = 1'b0;
        tick();
        tick();
        iClrStatus = 1'b1;
        tick();
        iClrStatus = 1'b0;
        check("clrwin_done",  oComputeDone, 1);
        check("clrwin_count", oInstrCount,  0);
        iCtrlnCe = 1'b1;
        tick();

        // iEnable low only masks oAPUReady.
        iEnable = 1'b0;
        tick();
        check("en_low_ready", oAPUReady, 0);
        dispatch(32'h0000_0000, 0, s_or, s_n, d_c, pul, cfg);
        check("en_low_pulses", pul, 1);
        check("en_low_count",  oInstrCount, 1);
        iEnable = 1'b1;

        // Asynchronous reset while waiting on an engine.
        iInstruction = 32'h1000_0077; iCtrlnCe = 1'b0;
        tick(); tick(); tick();
        iCtrlnCe = 1'b1;
        check("wait_opc",  oCurOpcode, 1);
        check("wait_busy", oBusy,      1);
        #2 nRst = 1'b0;
        #1;
        check("arst_busy",  oBusy,       0);
        check("arst_cfg",   oEngCfg,     0);
        check("arst_opc",   oCurOpcode,  0);
        check("arst_count", oInstrCount, 0);
        check("arst_start", oEngStart,   0);
        tick();
        nRst = 1'b1;
        tick();

`ifdef APU_DISPATCH_WATCHDOG_EN
        d_c = -1;
        iInstruction = 32'h1000_0001; iCtrlnCe = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            tick();
            if (c == 2) iCtrlnCe = 1'b1;
            if (oComputeDone && d_c < 0) d_c = c;
            if (d_c >= 0) break;
        end
        check("wdt_done_at", d_c,      12);
        check("wdt_timeout", oTimeout, 1);
        iClrStatus = 1'b1;
        tick();
        iClrStatus = 1'b0;
        check("wdt_clr", oTimeout, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
